// File: rtl/trace_dispatch_arbiter_pkg.sv
// Shared types for the trace repository: entry payload, response kinds, arbiter FSM states.
package trace_repository_datatypes;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] addr;
    logic [7:0]  op;
  } trace_format;

  typedef enum logic [1:0] {
    RESP_ENTRY     = 2'd0,
    RESP_CANCELLED = 2'd1,
    RESP_COMPLETE  = 2'd2
  } resp_kind_t;

  typedef enum logic [1:0] {F_IDLE, F_REQ, F_RESP, F_DRAIN} fetch_state_t;

  typedef enum logic {D_IDLE, D_WAIT} done_state_t;

  // Round-robin successor of a granted id, wrapping at n.
  function automatic int rr_next(int id, int n);
    return (id + 1 >= n) ? 0 : id + 1;
  endfunction

endpackage

// File: rtl/trace_dispatch_arbiter_if.sv
// Worker-array / repository bundle seen by the dispatch arbiter.
interface trace_dispatch_arbiter_if
  import trace_repository_datatypes::*;
#(
  parameter int N_WORKERS     = 4,
  parameter int TRACE_ENTRIES = 2048
);
  localparam int IDX_W = $clog2(TRACE_ENTRIES);

  logic [N_WORKERS-1:0]       worker_req;
  logic [N_WORKERS-1:0]       resp_valid;
  resp_kind_t                 resp_kind;
  trace_format                resp_trace;
  logic [IDX_W-1:0]           resp_index;
  logic [N_WORKERS-1:0]       done_req;
  logic [N_WORKERS*IDX_W-1:0] done_index;
  logic [N_WORKERS-1:0]       done_processing_flag;
  logic [N_WORKERS-1:0]       done_ack;
  logic                       trace_req;
  logic                       cancel;
  trace_format                trace_in;
  logic [IDX_W-1:0]           trace_index_in;
  logic                       entry_valid;
  logic                       cancelled;
  logic                       processing_complete;
  logic [IDX_W-1:0]           index_done;
  logic                       mark_done;
  logic                       processing_flag;
  logic                       mark_done_valid;

  // Arbiter side.
  modport master (
    input  worker_req, done_req, done_index, done_processing_flag,
           trace_in, trace_index_in, entry_valid, cancelled, processing_complete,
           mark_done_valid,
    output resp_valid, resp_kind, resp_trace, resp_index, done_ack,
           trace_req, cancel, index_done, mark_done, processing_flag
  );

  // Workers plus repository side.
  modport slave (
    output worker_req, done_req, done_index, done_processing_flag,
           trace_in, trace_index_in, entry_valid, cancelled, processing_complete,
           mark_done_valid,
    input  resp_valid, resp_kind, resp_trace, resp_index, done_ack,
           trace_req, cancel, index_done, mark_done, processing_flag
  );

endinterface

// File: rtl/trace_dispatch_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first requester at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         grant,
  output logic [$clog2(N)-1:0] grant_id
);
  localparam int PW = $clog2(N);

  // Scan from the far end back toward ptr so the closest requester wins last.
  always_comb begin
    int j;
    j        = 0;
    grant    = '0;
    grant_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % N;
      if (req[j]) begin
        grant    = '0;
        grant[j] = 1'b1;
        grant_id = PW'(j);
      end
    end
  end

endmodule

// File: rtl/trace_dispatch_arbiter.sv
// Shares the repository fetch port and mark-done port among N_WORKERS engines.
module trace_dispatch_arbiter
  import trace_repository_datatypes::*;
#(
  parameter int N_WORKERS      = 4,
  parameter int TRACE_ENTRIES  = 2048,
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  trace_dispatch_arbiter_if.master bus
);
  localparam int IDX_W = $clog2(TRACE_ENTRIES);
  localparam int PW    = $clog2(N_WORKERS);
  localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  fetch_state_t           fst_q, fst_d;
  logic [PW-1:0]          rr_ptr_q, rr_ptr_d, gid_q, gid_d, f_gid;
  logic [N_WORKERS-1:0]   goh_q, goh_d, f_goh;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   trace_req_q, trace_req_d, cancel_q, cancel_d;
  logic [N_WORKERS-1:0]   resp_valid_q, resp_valid_d;
  resp_kind_t             kind_q, kind_d;
  trace_format            trace_q, trace_d;
  logic [IDX_W-1:0]       index_q, index_d;

  done_state_t            dst_q, dst_d;
  logic [PW-1:0]          done_ptr_q, done_ptr_d, did_q, did_d, d_gid;
  logic [N_WORKERS-1:0]   doh_q, doh_d, d_goh;
  logic [N_WORKERS-1:0]   done_ack_q, done_ack_d;
  logic [IDX_W-1:0]       index_done_q, index_done_d;
  logic                   mark_done_q, mark_done_d, pflag_q, pflag_d;

  rr_arbiter #(.N(N_WORKERS)) u_fetch_rr (
    .req(bus.worker_req), .ptr(rr_ptr_q), .grant(f_goh), .grant_id(f_gid)
  );

  rr_arbiter #(.N(N_WORKERS)) u_done_rr (
    .req(bus.done_req), .ptr(done_ptr_q), .grant(d_goh), .grant_id(d_gid)
  );

  // Fetch FSM next state: grant, wait for a repository flag with watchdog, pulse, drain.
  always_comb begin
    fst_d        = fst_q;
    rr_ptr_d     = rr_ptr_q;
    gid_d        = gid_q;
    goh_d        = goh_q;
    timer_d      = timer_q;
    trace_req_d  = trace_req_q;
    cancel_d     = cancel_q;
    resp_valid_d = '0;
    kind_d       = kind_q;
    trace_d      = trace_q;
    index_d      = index_q;
    case (fst_q)
      F_IDLE: if (|bus.worker_req) begin
        gid_d       = f_gid;
        goh_d       = f_goh;
        trace_req_d = 1'b1;
        timer_d     = '0;
        fst_d       = F_REQ;
      end
      F_REQ: begin
        // Saturating timer; cancel is sticky once the limit is hit.
        if (timer_q != TMAX) timer_d = timer_q + 1'b1;
        if (timer_d == TMAX) cancel_d = 1'b1;
        if (bus.entry_valid || bus.cancelled || bus.processing_complete) begin
          kind_d  = bus.entry_valid ? RESP_ENTRY :
                    bus.cancelled   ? RESP_CANCELLED : RESP_COMPLETE;
          trace_d = bus.trace_in;
          index_d = bus.trace_index_in;
          fst_d   = F_RESP;
        end
      end
      F_RESP: begin
        resp_valid_d = goh_q;
        trace_req_d  = 1'b0;
        cancel_d     = 1'b0;
        rr_ptr_d     = PW'(rr_next(int'(gid_q), N_WORKERS));
        fst_d        = F_DRAIN;
      end
      // processing_complete is sticky, so only the pulse-style flags gate the drain.
      F_DRAIN: if (!bus.entry_valid && !bus.cancelled) fst_d = F_IDLE;
      default: fst_d = F_IDLE;
    endcase
  end

  // Fetch FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fst_q        <= F_IDLE;
      rr_ptr_q     <= '0;
      gid_q        <= '0;
      goh_q        <= '0;
      timer_q      <= '0;
      trace_req_q  <= 1'b0;
      cancel_q     <= 1'b0;
      resp_valid_q <= '0;
      kind_q       <= RESP_ENTRY;
      trace_q      <= '0;
      index_q      <= '0;
    end else begin
      fst_q        <= fst_d;
      rr_ptr_q     <= rr_ptr_d;
      gid_q        <= gid_d;
      goh_q        <= goh_d;
      timer_q      <= timer_d;
      trace_req_q  <= trace_req_d;
      cancel_q     <= cancel_d;
      resp_valid_q <= resp_valid_d;
      kind_q       <= kind_d;
      trace_q      <= trace_d;
      index_q      <= index_d;
    end
  end

  // Done FSM next state: one mark_done pulse per write-back, ack on repository confirm.
  always_comb begin
    dst_d        = dst_q;
    done_ptr_d   = done_ptr_q;
    did_d        = did_q;
    doh_d        = doh_q;
    done_ack_d   = '0;
    index_done_d = index_done_q;
    mark_done_d  = 1'b0;
    pflag_d      = pflag_q;
    case (dst_q)
      D_IDLE: if (|bus.done_req) begin
        did_d        = d_gid;
        doh_d        = d_goh;
        index_done_d = bus.done_index[int'(d_gid)*IDX_W +: IDX_W];
        pflag_d      = bus.done_processing_flag[d_gid];
        mark_done_d  = 1'b1;
        dst_d        = D_WAIT;
      end
      D_WAIT: if (bus.mark_done_valid) begin
        done_ack_d = doh_q;
        done_ptr_d = PW'(rr_next(int'(did_q), N_WORKERS));
        dst_d      = D_IDLE;
      end
      default: dst_d = D_IDLE;
    endcase
  end

  // Done FSM state and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dst_q        <= D_IDLE;
      done_ptr_q   <= '0;
      did_q        <= '0;
      doh_q        <= '0;
      done_ack_q   <= '0;
      index_done_q <= '0;
      mark_done_q  <= 1'b0;
      pflag_q      <= 1'b0;
    end else begin
      dst_q        <= dst_d;
      done_ptr_q   <= done_ptr_d;
      did_q        <= did_d;
      doh_q        <= doh_d;
      done_ack_q   <= done_ack_d;
      index_done_q <= index_done_d;
      mark_done_q  <= mark_done_d;
      pflag_q      <= pflag_d;
    end
  end

  assign bus.resp_valid      = resp_valid_q;
  assign bus.resp_kind       = kind_q;
  assign bus.resp_trace      = trace_q;
  assign bus.resp_index      = index_q;
  assign bus.trace_req       = trace_req_q;
  assign bus.cancel          = cancel_q;
  assign bus.done_ack        = done_ack_q;
  assign bus.index_done      = index_done_q;
  assign bus.mark_done       = mark_done_q;
  assign bus.processing_flag = pflag_q;

endmodule

// File: tb/tb_trace_dispatch_arbiter.sv
// Directed bench for trace_dispatch_arbiter: vector table plus multi-cycle sequences.
module tb_trace_dispatch_arbiter;
  import trace_repository_datatypes::*;

  localparam int N  = 4;
  localparam int TE = 2048;
  localparam int TO = 8;
  localparam int IW = $clog2(TE);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  trace_dispatch_arbiter_if #(.N_WORKERS(N), .TRACE_ENTRIES(TE)) bus ();

  trace_dispatch_arbiter #(.N_WORKERS(N), .TRACE_ENTRIES(TE), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [3:0]    req;
    logic [2:0]    flg;      // {complete, cancelled, entry}
    logic [IW-1:0] idx;
    logic [3:0]    exp_vld;
    resp_kind_t    exp_kind;
  } vec_t;

  vec_t       vt [8];
  int         checks = 0;
  int         errors = 0;
  int         order [4];
  int         exp_idx [2];
  logic       exp_flg [2];
  logic [3:0] exp_ack [2];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic trace_format mk_trace(int i);
    trace_format t;
    t.pc   = 32'h1000_0000 + 32'(i);
    t.addr = 32'hA5A5_0000 ^ 32'(i);
    t.op   = 8'(i * 3 + 1);
    return t;
  endfunction

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, bus.resp_valid, 0);
    chk({tag, "_resp_kind"},  bus.resp_kind, 0);
    chk({tag, "_resp_trace"}, bus.resp_trace, 0);
    chk({tag, "_resp_index"}, bus.resp_index, 0);
    chk({tag, "_done_ack"},   bus.done_ack, 0);
    chk({tag, "_trace_req"},  bus.trace_req, 0);
    chk({tag, "_cancel"},     bus.cancel, 0);
    chk({tag, "_index_done"}, bus.index_done, 0);
    chk({tag, "_mark_done"},  bus.mark_done, 0);
    chk({tag, "_pflag"},      bus.processing_flag, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n, last, cyc, early, stale, md_n, ack_n, md_cyc;
    logic pend;

    // Rows applied back to back; the round-robin pointer carries from row to row.
    vt[0] = '{4'b0110, 3'b001, 11'd5,     4'b0010, RESP_ENTRY};
    vt[1] = '{4'b0110, 3'b001, 11'd9,     4'b0100, RESP_ENTRY};
    vt[2] = '{4'b1001, 3'b010, 11'd3,     4'b1000, RESP_CANCELLED};
    vt[3] = '{4'b1001, 3'b100, 11'h7FF,   4'b0001, RESP_COMPLETE};
    vt[4] = '{4'b1111, 3'b001, 11'h400,   4'b0010, RESP_ENTRY};
    vt[5] = '{4'b0001, 3'b011, 11'd1,     4'b0001, RESP_ENTRY};
    vt[6] = '{4'b1100, 3'b110, 11'd2,     4'b0100, RESP_CANCELLED};
    vt[7] = '{4'b0111, 3'b111, 11'd0,     4'b0001, RESP_ENTRY};
    order   = '{3, 0, 1, 2};
    exp_idx = '{7, 12};
    exp_flg = '{1'b1, 1'b0};
    exp_ack = '{4'b0001, 4'b1000};

    bus.worker_req = '0; bus.done_req = '0; bus.done_index = '0;
    bus.done_processing_flag = '0; bus.trace_in = '0; bus.trace_index_in = '0;
    bus.entry_valid = 1'b0; bus.cancelled = 1'b0; bus.processing_complete = 1'b0;
    bus.mark_done_valid = 1'b0;

    repeat (3) tick;
    chk_all_zero("rst");
    rst_n = 1'b1;
    tick;

    // Single fetch transactions from the vector table.
    for (int i = 0; i < 8; i++) begin
      bus.worker_req = vt[i].req;
      tick;
      chk("req_lat", bus.trace_req, 1);
      bus.entry_valid         = vt[i].flg[0];
      bus.cancelled           = vt[i].flg[1];
      bus.processing_complete = vt[i].flg[2];
      bus.trace_index_in      = vt[i].idx;
      bus.trace_in            = mk_trace(i);
      tick;
      bus.entry_valid = 1'b0; bus.cancelled = 1'b0; bus.processing_complete = 1'b0;
      chk("resp_early", bus.resp_valid, 0);
      tick;
      chk("resp_who", bus.resp_valid, vt[i].exp_vld);
      chk("resp_kind", bus.resp_kind, vt[i].exp_kind);
      chk("resp_index", bus.resp_index, vt[i].idx);
      if (vt[i].exp_kind == RESP_ENTRY) chk("resp_trace", bus.resp_trace, mk_trace(i));
      chk("req_drop", bus.trace_req, 0);
      bus.worker_req = '0;
      tick;
      chk("resp_pulse", bus.resp_valid, 0);
      tick;
    end

    // Watchdog: silent repository, then a late cancelled answer. Pointer is 1 -> worker 2.
    bus.worker_req = 4'b0100;
    tick;
    chk("to_req", bus.trace_req, 1);
    early = 0;
    for (int c = 1; c < TO; c++) begin
      tick;
      if (bus.cancel) early++;
    end
    chk("to_cancel_early", early, 0);
    tick;
    chk("to_cancel_rise", bus.cancel, 1);
    repeat (20) tick;
    chk("to_cancel_hold", bus.cancel, 1);
    chk("to_req_hold", bus.trace_req, 1);
    chk("to_no_resp", bus.resp_valid, 0);
    bus.cancelled = 1'b1;
    tick;
    bus.cancelled = 1'b0;
    tick;
    chk("to_resp_who", bus.resp_valid, 4'b0100);
    chk("to_resp_kind", bus.resp_kind, RESP_CANCELLED);
    chk("to_cancel_drop", bus.cancel, 0);
    chk("to_req_drop", bus.trace_req, 0);
    bus.worker_req = '0;
    tick; tick;

    // Sticky processing_complete: all four workers served in order, 4 cycles apart.
    bus.processing_complete = 1'b1;
    bus.worker_req = 4'b1111;
    n = 0; last = 0; cyc = 0;
    for (int c = 0; c < 40 && n < 4; c++) begin
      tick;
      cyc++;
      if (bus.resp_valid != 0) begin
        chk("cmp_who", bus.resp_valid, 4'b0001 << order[n]);
        chk("cmp_kind", bus.resp_kind, RESP_COMPLETE);
        if (n > 0) chk("cmp_spacing", cyc - last, 4);
        last = cyc;
        bus.worker_req = bus.worker_req & ~bus.resp_valid;
        n++;
      end
    end
    chk("cmp_count", n, 4);
    bus.processing_complete = 1'b0;
    bus.worker_req = '0;
    tick; tick;

    // Write-backs from workers 0 and 3; repository confirms two cycles after mark_done.
    bus.done_index = '0;
    bus.done_index[0*IW +: IW] = 11'd7;
    bus.done_index[3*IW +: IW] = 11'd12;
    bus.done_processing_flag = 4'b0001;
    bus.done_req = 4'b1001;
    md_n = 0; ack_n = 0; md_cyc = 0; pend = 1'b0;
    for (int c = 0; c < 40 && ack_n < 2; c++) begin
      tick;
      bus.mark_done_valid = pend;
      pend = bus.mark_done;
      if (bus.mark_done) begin
        if (md_n < 2) begin
          chk("md_index", bus.index_done, exp_idx[md_n]);
          chk("md_flag", bus.processing_flag, exp_flg[md_n]);
        end
        md_cyc = c;
        md_n++;
      end
      if (bus.done_ack != 0) begin
        if (ack_n < 2) chk("ack_who", bus.done_ack, exp_ack[ack_n]);
        chk("ack_lat", c - md_cyc, 2);
        bus.done_req = bus.done_req & ~bus.done_ack;
        ack_n++;
      end
    end
    bus.mark_done_valid = 1'b0;
    chk("md_count", md_n, 2);
    chk("ack_count", ack_n, 2);
    tick; tick;

    // Worker 2 fetches and writes back at the same time.
    bus.worker_req = 4'b0100;
    bus.done_req = 4'b0100;
    bus.done_index[2*IW +: IW] = 11'd33;
    bus.done_processing_flag = 4'b0100;
    tick;
    chk("sim_trace_req", bus.trace_req, 1);
    chk("sim_mark_done", bus.mark_done, 1);
    chk("sim_index_done", bus.index_done, 33);
    chk("sim_pflag", bus.processing_flag, 1);
    bus.entry_valid = 1'b1;
    bus.trace_index_in = 11'd21;
    bus.trace_in = mk_trace(40);
    tick;
    bus.entry_valid = 1'b0;
    chk("sim_md_pulse", bus.mark_done, 0);
    bus.mark_done_valid = 1'b1;
    tick;
    bus.mark_done_valid = 1'b0;
    chk("sim_resp_who", bus.resp_valid, 4'b0100);
    chk("sim_resp_index", bus.resp_index, 21);
    chk("sim_ack", bus.done_ack, 4'b0100);
    bus.worker_req = '0;
    bus.done_req = '0;
    tick;
    chk("sim_resp_pulse", bus.resp_valid, 0);
    chk("sim_ack_pulse", bus.done_ack, 0);
    tick; tick;

    // Reset in the middle of a fetch and a write-back. Pointer is 3 -> worker 3 first.
    bus.worker_req = 4'b1001;
    bus.done_req = 4'b0010;
    bus.done_index[1*IW +: IW] = 11'd99;
    bus.done_processing_flag = 4'b0010;
    tick;
    chk("pre_rst_req", bus.trace_req, 1);
    chk("pre_rst_md", bus.mark_done, 1);
    tick;
    chk("pre_rst_idx", bus.index_done, 99);
    #2 rst_n = 1'b0;
    #1;
    chk_all_zero("mid_rst");
    bus.done_req = '0;
    tick;
    rst_n = 1'b1;
    stale = 0;
    for (int c = 0; c < 5; c++) begin
      tick;
      if (bus.resp_valid != 0) stale++;
    end
    chk("post_rst_stale", stale, 0);
    chk("post_rst_req", bus.trace_req, 1);
    bus.entry_valid = 1'b1;
    bus.trace_index_in = 11'd77;
    tick;
    bus.entry_valid = 1'b0;
    tick;
    chk("post_rst_ptr0", bus.resp_valid, 4'b0001);
    chk("post_rst_index", bus.resp_index, 77);
    bus.worker_req = '0;
    tick; tick;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trace_dispatch_arbiter.md
# trace_dispatch_arbiter

Shares the single request/mark-done port pair of the trace repository between `N_WORKERS` processing engines. Round-robin arbitration serialises `trace_req` transactions and returns each entry, cancellation or completion to the granted worker only. A watchdog cancels a stalled request. A second, independent round-robin channel serialises `mark_done` write-backs. The block sits between the repository and the engine array.

## Interface
- `N_WORKERS`, 4: number of requesting engines (2..16).
- `TRACE_ENTRIES`, 2048: repository depth; `IDX_W = $clog2(TRACE_ENTRIES)`.
- `TIMEOUT_CYCLES`, 64: cycles `trace_req` stays outstanding before `cancel` is raised (≥1).
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `worker_req` in N_WORKERS: per-worker fetch request; level, held until that worker's `resp_valid`.
- `resp_valid` out N_WORKERS: one-cycle pulse to the serviced worker; one-hot or zero.
- `resp_kind` out 2: `RESP_ENTRY`, `RESP_CANCELLED` or `RESP_COMPLETE`; valid with `resp_valid`.
- `resp_trace` out trace_format: entry payload; valid when kind is `RESP_ENTRY`.
- `resp_index` out IDX_W: repository index of the entry.
- `done_req` in N_WORKERS: per-worker write-back request; level, held until `done_ack`.
- `done_index` in N_WORKERS*IDX_W: packed; slice w belongs to worker w.
- `done_processing_flag` in N_WORKERS: per-worker flag value to write.
- `done_ack` out N_WORKERS: one-cycle pulse, one-hot or zero.
- `trace_req` out 1; `cancel` out 1: to the repository.
- `trace_in` in trace_format; `trace_index_in` in IDX_W: from the repository.
- `entry_valid`, `cancelled`, `processing_complete` in 1 each: from the repository.
- `index_done` out IDX_W; `mark_done` out 1; `processing_flag` out 1: to the repository.
- `mark_done_valid` in 1: from the repository.

## Operation
- The fetch FSM has four states: `F_IDLE`, `F_REQ`, `F_RESP`, `F_DRAIN`.
  - `F_IDLE`: if any `worker_req` is set, grant the first requester at or after `rr_ptr` (wrapping modulo N_WORKERS). Latch `grant_id`, set `trace_req`, clear the timer, go to `F_REQ`.
  - `F_REQ`: `trace_req` stays at 1 and the timer increments.
    - When the timer reaches `TIMEOUT_CYCLES`, `cancel` is set and held.
    - When `entry_valid`, `cancelled` or `processing_complete` is sampled high, go to `F_RESP`.
    - Priority of kind is entry > cancelled > complete.
    - Capture `trace_in` and `trace_index_in`.
  - `F_RESP`: pulse `resp_valid[grant_id]`, clear `trace_req` and `cancel`, set `rr_ptr = grant_id+1` (wrapping), go to `F_DRAIN`.
  - `F_DRAIN`: wait until `entry_valid` and `cancelled` are both 0, then go to `F_IDLE`. `processing_complete` is level/sticky and is ignored here.
- Requests cannot be withdrawn. A `worker_req` that drops during `F_REQ` does not abort the transaction; the response is still pulsed to that worker.
- The done FSM has two states, `D_IDLE` and `D_WAIT`, and its own `done_ptr`.
  - `D_IDLE`: pick a requester by round-robin, drive `index_done` and `processing_flag` from its slice, pulse `mark_done` for 1 cycle, go to `D_WAIT`.
  - `D_WAIT`: on `mark_done_valid`, pulse `done_ack[w]`, set `done_ptr = w+1`, go to `D_IDLE`.
- The fetch and done FSMs run concurrently. The same worker may be active in both.
- Reset value of every output is 0: `resp_*`, `done_ack`, `trace_req`, `cancel`, `index_done`, `mark_done`, `processing_flag`.
- Reset also clears both FSMs to their IDLE states, both pointers to 0 and the timer to 0.
- Reset asserted mid-transaction abandons the transaction. No response is emitted after reset.

## Timing
- Request latency: `worker_req` sampled high at edge k gives `trace_req`=1 after edge k.
- Response latency: a repository flag sampled high at edge m gives `resp_valid` high for exactly the cycle after edge m+1.
- Minimum spacing between grants is 4 cycles.
- `cancel` rises after edge k+TIMEOUT_CYCLES when no flag has arrived.
- The timer width is `$clog2(TIMEOUT_CYCLES+1)` bits and saturates; it never wraps.
- `mark_done` is high for exactly one cycle per write-back. The earliest `done_ack` is 2 cycles after `mark_done`.

## Structure
- Add to the `trace_repository_datatypes` package:
  - the `resp_kind_t` enum (`RESP_ENTRY`=0, `RESP_CANCELLED`=1, `RESP_COMPLETE`=2);
  - the fetch-state and done-state enums.
- `trace_format` is reused from the same package.
- Sub-module `rr_arbiter`, parameterised on N, instantiated twice:
  - inputs `req[N]` and `ptr`;
  - outputs a one-hot `grant` and its index `grant_id`;
  - combinational; the pointer update stays in the parent.

## Test plan
- `worker_req`=4'b0110 with `rr_ptr`=0; repository returns `entry_valid`, index 5:
  - → worker 1 gets `RESP_ENTRY`, `resp_index`=5;
  - → worker 2 is granted next;
  - → `rr_ptr` ends at 3.
- `TIMEOUT_CYCLES`=8 and the repository stays silent → `cancel` rises 8 cycles after `trace_req`; the repository then answers `cancelled` → `RESP_CANCELLED` to the requester; `cancel` and `trace_req` drop.
- `processing_complete` held high permanently → every request gets `RESP_COMPLETE`; the FSM never hangs in `F_DRAIN`.
- `done_req`=4'b1001 with indices 7 and 12 → two `mark_done` pulses in order: 7 (worker 0), then 12 (worker 3). Each `done_ack` arrives after its `mark_done_valid`.
- A fetch and a write-back are active simultaneously for worker 2 → both complete independently and neither adds latency to the other.
- `rst_n` asserted while in `F_REQ` → all outputs are 0 immediately; after release, no stale `resp_valid`, and `rr_ptr`=0.
